// File: rtl/inst_rom_ctrl_pkg.sv
// rtl/inst_rom_ctrl_pkg.sv - shared widths, constants and loader state encoding
package inst_rom_ctrl_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;
    localparam logic [RegBus-1:0] NopInst  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_ERROR   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/inst_rom_array.sv
// rtl/inst_rom_array.sv - word storage, synchronous write, asynchronous read, no reset
module inst_rom_array
    import inst_rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [RegBus-1:0]   i_wdata,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [RegBus-1:0]   o_rdata
);

    logic [RegBus-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_ctrl.sv
// rtl/inst_rom_ctrl.sv - instruction fetch responder with byte-serial boot loader
// Optional running XOR checksum of committed words: INST_ROM_CSUM_EN
module inst_rom_ctrl
    import inst_rom_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [RegBus-1:0]      rom_data_o,
    input  logic                   ld_start_i,
    input  logic                   ld_valid_i,
    input  logic [7:0]             ld_byte_i,
    input  logic                   ld_last_i,
    output logic                   ld_ready_o,
    output logic                   ld_busy_o,
    output logic                   ld_done_o,
    output logic                   ld_err_o,
    output logic [ADDR_W:0]        ld_count_o,
    output logic [RegBus-1:0]      ld_csum_o
);

    ld_state_e           r_state, w_state_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [1:0]          r_idx;
    logic [RegBus-1:0]   r_word, w_word_next;
    logic                r_last;
    logic [ADDR_W:0]     r_count;
    logic                r_err;
    logic                w_accept, w_we, w_ptr_max;
    logic [RegBus-1:0]   w_rdata;
    logic                w_unused;

    // The storage is never reset, so INIT_ZERO only documents that choice.
    assign w_unused  = ^{rom_addr_i[1:0], (INIT_ZERO != 0)};
    assign w_ptr_max = (r_ptr == {ADDR_W{1'b1}});

    always_comb begin
        w_word_next = r_word;
        case (r_idx)
            2'd0:    w_word_next[31:24] = ld_byte_i;
            2'd1:    w_word_next[23:16] = ld_byte_i;
            2'd2:    w_word_next[15:8]  = ld_byte_i;
            default: w_word_next[7:0]   = ld_byte_i;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        ld_ready_o   = 1'b0;
        ld_done_o    = 1'b0;
        w_accept     = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ld_start_i) w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                ld_ready_o = 1'b1;
                if (ld_start_i) begin
                    w_state_next = ST_COLLECT;
                end else if (ld_valid_i) begin
                    w_accept = 1'b1;
                    if (r_idx == 2'd3 || ld_last_i) w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (ld_start_i) begin
                    w_state_next = ST_COLLECT;
                end else begin
                    w_we = 1'b1;
                    if (r_last) begin
                        ld_done_o    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (w_ptr_max) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_state_next = ST_COLLECT;
                    end
                end
            end
            default: begin
                ld_ready_o = 1'b1;
                if (ld_start_i) begin
                    w_state_next = ST_COLLECT;
                end else if (ld_valid_i && ld_last_i) begin
                    ld_done_o    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_idx   <= 2'd0;
            r_word  <= ZeroWord;
            r_last  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (ld_start_i) begin
            r_ptr   <= '0;
            r_idx   <= 2'd0;
            r_word  <= ZeroWord;
            r_last  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_word <= w_word_next;
            r_idx  <= r_idx + 2'd1;
            r_last <= ld_last_i;
        end else if (w_we) begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= r_count + 1'b1;
            r_word  <= ZeroWord;
            r_idx   <= 2'd0;
            if (!r_last && w_ptr_max) r_err <= 1'b1;
        end
    end

`ifdef INST_ROM_CSUM_EN
    logic [RegBus-1:0] r_csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= ZeroWord;
        end else if (ld_start_i) begin
            r_csum <= ZeroWord;
        end else if (w_we) begin
            r_csum <= r_csum ^ r_word;
        end
    end

    assign ld_csum_o = r_csum;
`else
    assign ld_csum_o = ZeroWord;
`endif

    inst_rom_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (r_word),
        .i_raddr (rom_addr_i[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    assign ld_busy_o  = (r_state != ST_IDLE);
    assign ld_err_o   = r_err;
    assign ld_count_o = r_count;

    // Fetches see NOP for the whole load, including the commit cycle.
    assign rom_data_o = (rom_ce_i && !ld_busy_o && rom_addr_i[InstAddrBus-1:ADDR_W+2] == '0)
                        ? w_rdata : NopInst;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// tb/tb_inst_rom_ctrl.sv - directed self-checking bench for inst_rom_ctrl
module tb_inst_rom_ctrl;

    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rom_ce_i = 1'b0;
    logic [31:0]     rom_addr_i = '0;
    logic [31:0]     rom_data_o;
    logic            ld_start_i = 1'b0;
    logic            ld_valid_i = 1'b0;
    logic [7:0]      ld_byte_i = '0;
    logic            ld_last_i = 1'b0;
    logic            ld_ready_o, ld_busy_o, ld_done_o, ld_err_o;
    logic [AW:0]     ld_count_o;
    logic [31:0]     ld_csum_o;

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0;
    int done_before;

    inst_rom_ctrl #(.ADDR_W(AW), .INIT_ZERO(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_last_i  (ld_last_i),
        .ld_ready_o (ld_ready_o),
        .ld_busy_o  (ld_busy_o),
        .ld_done_o  (ld_done_o),
        .ld_err_o   (ld_err_o),
        .ld_count_o (ld_count_o),
        .ld_csum_o  (ld_csum_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && ld_done_o === 1'b1) done_cnt++;
    end

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } fetch_vec_t;

    fetch_vec_t fv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rom_ce_i = 1'b1;
        rom_addr_i = addr;
        #1;
        chk(name, rom_data_o, exp);
        rom_ce_i = 1'b0;
    endtask

    task automatic start_pulse();
        ld_start_i = 1'b1;
        @(posedge clk); #1;
        ld_start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        ld_last_i  = last;
        while (ld_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            n_total++;
            $display("FAIL send_timeout actual=not_ready expected=ready");
        end
        @(posedge clk); #1;
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ld_busy_o !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
    endtask

    logic [31:0] csum1, csum4, csum5;

    initial begin
`ifdef INST_ROM_CSUM_EN
        csum1 = 32'h0003_0003;
        csum4 = 32'hAABB_CC00;
        csum5 = 32'h0000_0010;
`else
        csum1 = 32'h0;
        csum4 = 32'h0;
        csum5 = 32'h0;
`endif
        fv[0] = '{1'b1, 32'h0000_0004, 32'h3402_0002, "fetch_w1"};
        fv[1] = '{1'b1, 32'h0000_0006, 32'h3402_0002, "fetch_w1_unaligned"};
        fv[2] = '{1'b0, 32'h0000_0004, 32'h0000_0000, "fetch_ce_off"};
        fv[3] = '{1'b1, 32'h0000_0000, 32'h3401_0001, "fetch_w0"};
        fv[4] = '{1'b1, 32'h0000_0003, 32'h3401_0001, "fetch_w0_unaligned"};
        fv[5] = '{1'b1, 32'h0000_0010, 32'h0000_0000, "fetch_out_of_range"};
        fv[6] = '{1'b1, 32'h8000_0000, 32'h0000_0000, "fetch_high_bit"};

        #12;
        chk("rst_ready", {31'd0, ld_ready_o}, 32'd0);
        chk("rst_busy",  {31'd0, ld_busy_o},  32'd0);
        chk("rst_done",  {31'd0, ld_done_o},  32'd0);
        chk("rst_err",   {31'd0, ld_err_o},   32'd0);
        chk("rst_count", {29'd0, ld_count_o}, 32'd0);
        chk("rst_csum",  ld_csum_o,           32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two-word image
        start_pulse();
        chk("t1_ready_collect", {31'd0, ld_ready_o}, 32'd1);
        send(8'h34, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
        send(8'h34, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h02, 1'b1);
        wait_idle();
        chk("t1_count", {29'd0, ld_count_o}, 32'd2);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_csum", ld_csum_o, csum1);

        for (int i = 0; i < 7; i++) begin
            rom_ce_i = fv[i].ce;
            rom_addr_i = fv[i].addr;
            #1;
            chk(fv[i].name, rom_data_o, fv[i].exp);
        end
        rom_ce_i = 1'b0;

        // Short image, fetch during load and during commit
        @(posedge clk); #1;
        start_pulse();
        chk("t4_busy", {31'd0, ld_busy_o}, 32'd1);
        fetch(32'h0, 32'h0, "t3_fetch_busy");
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        chk("t4_done_in_commit", {31'd0, ld_done_o}, 32'd1);
        fetch(32'h0, 32'h0, "t4_fetch_commit");
        wait_idle();
        fetch(32'h0, 32'hAABB_CC00, "t4_mem0");
        fetch(32'h4, 32'h3402_0002, "t4_mem1_kept");
        chk("t4_count", {29'd0, ld_count_o}, 32'd1);
        chk("t4_done_cnt", done_cnt, 32'd2);
        chk("t4_csum", ld_csum_o, csum4);

        // Overflow: 20 bytes into a 4-word array
        @(posedge clk); #1;
        start_pulse();
        for (int i = 1; i <= 16; i++) send(i[7:0], 1'b0);
        chk("t5_err_in_commit", {31'd0, ld_err_o}, 32'd0);
        @(posedge clk); #1;
        chk("t5_err_set", {31'd0, ld_err_o}, 32'd1);
        chk("t5_ready_error", {31'd0, ld_ready_o}, 32'd1);
        for (int i = 17; i <= 20; i++) send(i[7:0], (i == 20));
        wait_idle();
        chk("t5_done_cnt", done_cnt, 32'd3);
        chk("t5_err_sticky", {31'd0, ld_err_o}, 32'd1);
        chk("t5_count", {29'd0, ld_count_o}, 32'd4);
        chk("t5_csum", ld_csum_o, csum5);
        fetch(32'h0, 32'h0102_0304, "t5_mem0");
        fetch(32'hC, 32'h0D0E_0F10, "t5_mem3");

        // Async reset mid-collect
        @(posedge clk); #1;
        start_pulse();
        chk("t6_err_cleared", {31'd0, ld_err_o}, 32'd0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        chk("t6_count_pre", {29'd0, ld_count_o}, 32'd1);
        done_before = done_cnt;
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy",  {31'd0, ld_busy_o},  32'd0);
        chk("t6_rst_ready", {31'd0, ld_ready_o}, 32'd0);
        chk("t6_rst_count", {29'd0, ld_count_o}, 32'd0);
        chk("t6_rst_csum",  ld_csum_o,           32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("t6_no_done", done_cnt, done_before);
        fetch(32'h0, 32'h1122_3344, "t6_mem0_kept");
        fetch(32'h4, 32'h0506_0708, "t6_mem1_kept");

        start_pulse();
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
        @(posedge clk); #1;
        chk("t6_count_mid", {29'd0, ld_count_o}, 32'd1);
        start_pulse();
        chk("t6_restart_count", {29'd0, ld_count_o}, 32'd0);
        send(8'hB1, 1'b0); send(8'hB2, 1'b0); send(8'hB3, 1'b0); send(8'hB4, 1'b1);
        wait_idle();
        fetch(32'h0, 32'hB1B2_B3B4, "t6_reload_mem0");
        chk("t6_reload_count", {29'd0, ld_count_o}, 32'd1);
        chk("t6_reload_done", done_cnt, done_before + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_rom_ctrl.md
Name: inst_rom_ctrl

Overview:
- Instruction-memory responder for the CPU fetch port. It answers `rom_ce`/`rom_addr` from the fetch stage with a 32-bit instruction word in the same cycle.
- It also contains a byte-serial boot loader. The loader fills the word array through a valid/ready stream before the core runs.
- Sits beside the core top level, on the opposite end of the instruction ROM interface.

Parameters:
- ADDR_W, 10: word-address width; the array holds 2^ADDR_W 32-bit words.
- INIT_ZERO, 1: 1 means reset clears the loader state only; the array is never cleared (no reset on storage).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset asserted).
- rom_ce_i  in  1  fetch enable from the core.
- rom_addr_i  in  32  byte address from the core PC.
- rom_data_o  out  32  instruction word to the core.
- ld_start_i  in  1  one-cycle pulse that begins a load at word 0.
- ld_valid_i  in  1  byte-stream valid.
- ld_byte_i  in  8  stream byte.
- ld_last_i  in  1  marks the final byte of the image; qualified by ld_valid_i.
- ld_ready_o  out  1  loader accepts a byte this cycle.
- ld_busy_o  out  1  load in progress.
- ld_done_o  out  1  one-cycle pulse when the image is committed.
- ld_err_o  out  1  sticky overflow flag; cleared by ld_start_i.
- ld_count_o  out  ADDR_W+1  number of words committed in the current load.
- ld_csum_o  out  32  XOR checksum of committed words (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous) sets these values:
  - state=IDLE, ld_ready_o=0, ld_busy_o=0, ld_done_o=0, ld_err_o=0, ld_count_o=0, ld_csum_o=0.
  - Byte assembler and byte index cleared.
  - Array contents unaffected.
- Fetch read is combinational, with zero-cycle latency:
  - rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when rom_ce_i=1, ld_busy_o=0 and rom_addr_i[31:ADDR_W+2]==0.
  - In every other case rom_data_o = 32'h0 (MIPS NOP).
  - rom_addr_i[1:0] are ignored.
- Loader FSM states: IDLE, COLLECT, COMMIT, ERROR.
  - IDLE: ld_ready_o=0. On ld_start_i: go to COLLECT and clear the word pointer, byte index, count, csum and err.
  - COLLECT: ld_ready_o=1. Each cycle with ld_valid_i=1 accepts one byte.
    - Bytes pack big-endian: index 0 goes to bits [31:24], index 3 to bits [7:0].
    - Go to COMMIT when index 3 is accepted, or when ld_last_i=1 is accepted. Unfilled low bytes pad to 0.
  - COMMIT: one cycle, ld_ready_o=0.
    - Write the word to mem[ptr], then ptr++, count++, csum ^= word.
    - If the committed byte was last: ld_done_o=1 for this cycle, then IDLE.
    - Otherwise return to COLLECT.
    - If ptr wraps to 0 after writing word 2^ADDR_W-1 and it was not last: go to ERROR.
  - ERROR: ld_err_o=1, ld_ready_o=1. Incoming bytes are accepted and discarded, with no writes.
    - A byte with ld_last_i=1 returns the FSM to IDLE with ld_done_o=1; ld_err_o stays set.
- ld_busy_o=1 in COLLECT, COMMIT and ERROR.
- Throughput: at most 4 bytes per 5 cycles.
- ld_start_i outside IDLE restarts the load: pointer, count, csum and err are cleared. Any partially assembled word is dropped; words already written remain.
- ld_start_i together with ld_valid_i in the same cycle: start takes priority and the byte is not accepted.
- Reset mid-load leaves the array partially written and the FSM in IDLE. No done pulse is produced.
- A fetch during load returns NOP every cycle. This holds even in the cycle where COMMIT writes the fetched address; no write-through.

Optional Feature:
- Macro INST_ROM_CSUM_EN.
- Defined: ld_csum_o holds the running XOR of committed words, cleared on ld_start_i and on reset.
- Undefined: ld_csum_o is constant 0 and no checksum register is synthesized.

Decomposition:
- Shared package / defines file holds:
  - ZeroWord and the NOP constant.
  - Loader state encodings (IDLE=2'd0, COLLECT=2'd1, COMMIT=2'd2, ERROR=2'd3).
  - RegBus and InstAddrBus widths.
- One natural sub-module: inst_rom_array, the storage with a synchronous write port and an asynchronous read port. The FSM and the fetch muxing stay in inst_rom_ctrl.

Test Plan:
1. Reset, then start. Stream 8'h34,8'h01,8'h00,8'h01, 8'h34,8'h02,8'h00,8'h02 (last on byte 8) -> mem[0]=32'h34010001, mem[1]=32'h34020002, ld_count_o=2, ld_done_o pulses once, csum=32'h00030003 (INST_ROM_CSUM_EN defined) or 0 (undefined).
2. After load, rom_ce_i=1 with rom_addr_i=0x4 -> rom_data_o=32'h34020002 in the same cycle; rom_addr_i=0x6 -> same word; rom_ce_i=0 -> 0.
3. Fetch with rom_addr_i=(1<<(ADDR_W+2)) -> 0. Fetch at 0x0 while ld_busy_o=1 -> 0.
4. Stream 3 bytes AA,BB,CC with last on CC -> mem[0]=32'hAABBCC00, count=1, done pulse.
5. With ADDR_W=2: stream 20 bytes, last on byte 20 -> words 0..3 written, ld_err_o=1 after the 4th commit, bytes 17..20 discarded, done pulse, mem[0] not overwritten.
6. Assert rst=0 asynchronously mid-COLLECT (between clock edges) -> outputs reach reset values immediately. After release, a new start loads correctly, and a second ld_start_i mid-load resets count to 0.
